// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access path: op encoding, sequencer
// state encoding and the default DM depth. Used by decode, DM and dm_access_ctrl.
package dm_pkg;

  localparam int DM_MEM_DEPTH = 256;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_PUSH  = 2'd2,
    OP_POP   = 2'd3
  } dm_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CAPT  = 2'd2,
    S_RESP  = 2'd3
  } dm_state_e;

  // Ops whose result comes back from DM's registered read port.
  function automatic logic op_reads(dm_op_e op);
    return (op == OP_LOAD) || (op == OP_POP);
  endfunction

  // Ops that carry an explicit memory address.
  function automatic logic op_addressed(dm_op_e op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/dm_sp_reg.sv
// Stack pointer register with increment/decrement and full/empty flags.
// Optional feature macro: DM_STACK_GUARD_EN
//   defined   : sp moves freely in DATA_W bits, full at STACK_LIMIT, empty at
//               STACK_BASE (the caller refuses PUSH/POP on those flags).
//   undefined : flags never assert and sp wraps modulo MEM_DEPTH.
module dm_sp_reg
  import dm_pkg::*;
#(
  parameter int                 DATA_W      = 16,
  parameter int                 MEM_DEPTH   = DM_MEM_DEPTH,
  parameter logic [DATA_W-1:0]  STACK_BASE  = 'h00C0,
  parameter logic [DATA_W-1:0]  STACK_LIMIT = 'h0100
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inc,
  input  logic              i_dec,
  output logic [DATA_W-1:0] o_sp,
  output logic [DATA_W-1:0] o_sp_dec,
  output logic              o_full,
  output logic              o_empty
);

  localparam logic [DATA_W-1:0] LP_ONE = DATA_W'(1);
  localparam logic [DATA_W-1:0] LP_TOP = DATA_W'(MEM_DEPTH - 1);

  logic [DATA_W-1:0] r_sp;
  logic [DATA_W-1:0] w_sp_inc;
  logic [DATA_W-1:0] w_sp_dec;

`ifdef DM_STACK_GUARD_EN
  // Guarded: plain DATA_W arithmetic; the equality flags keep sp in range.
  assign w_sp_inc = r_sp + LP_ONE;
  assign w_sp_dec = r_sp - LP_ONE;
  assign o_full   = (r_sp == STACK_LIMIT);
  assign o_empty  = (r_sp == STACK_BASE);
`else
  // Unguarded: wrap inside the DM address space so dm_sp is always legal.
  assign w_sp_inc = (r_sp == LP_TOP) ? '0 : r_sp + LP_ONE;
  assign w_sp_dec = (r_sp == '0) ? LP_TOP : r_sp - LP_ONE;
  assign o_full   = 1'b0;
  assign o_empty  = 1'b0;
`endif

  // Stack pointer update; inc and dec are mutually exclusive by construction.
  always_ff @(posedge i_clk) begin
    if (i_rst)      r_sp <= STACK_BASE;
    else if (i_inc) r_sp <= w_sp_inc;
    else if (i_dec) r_sp <= w_sp_dec;
  end

  assign o_sp     = r_sp;
  assign o_sp_dec = w_sp_dec;

endmodule

// File: rtl/dm_access_ctrl.sv
// Sequencer in front of the data memory. Takes one request at a time, bounds
// checks it, drives one registered DM strobe, waits out DM's read latency and
// holds the response until the consumer takes it.
// Optional feature macro: DM_STACK_GUARD_EN (stack full/empty rejection,
// handled inside dm_sp_reg).
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int                 DATA_W      = 16,
  parameter int                 MEM_DEPTH   = DM_MEM_DEPTH,
  parameter logic [DATA_W-1:0]  STACK_BASE  = 'h00C0,
  parameter logic [DATA_W-1:0]  STACK_LIMIT = 'h0100
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [1:0]        i_req_op,
  input  logic [DATA_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_data,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_err,
  output logic              o_dm_load,
  output logic              o_dm_store,
  output logic              o_dm_push,
  output logic              o_dm_pop,
  output logic [DATA_W-1:0] o_dm_val,
  output logic [DATA_W-1:0] o_dm_rez,
  output logic [DATA_W-1:0] o_dm_sp,
  input  logic [DATA_W-1:0] i_dm_out,
  output logic [DATA_W-1:0] o_sp
);

  // One extra bit so MEM_DEPTH == 2**DATA_W still compares correctly.
  localparam logic [DATA_W:0] LP_DEPTH = (DATA_W+1)'(MEM_DEPTH);

  dm_state_e         r_state, w_next;
  dm_op_e            r_op;
  dm_op_e            w_op;
  logic              w_accept;
  logic              w_addr_oob;
  logic              w_req_err;
  logic              w_sp_inc, w_sp_dec;
  logic              w_full, w_empty;
  logic [DATA_W-1:0] w_sp, w_sp_dec_val;

  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;
  logic              r_dm_load, r_dm_store, r_dm_push, r_dm_pop;
  logic [DATA_W-1:0] r_dm_val, r_dm_rez, r_dm_sp;

  assign w_op       = dm_op_e'(i_req_op);
  assign w_accept   = (r_state == S_IDLE) && i_req_valid;
  assign w_addr_oob = ({1'b0, i_req_addr} >= LP_DEPTH);

  // sp moves once, at the end of the ISSUE cycle of an accepted PUSH/POP.
  assign w_sp_inc = (r_state == S_ISSUE) && (r_op == OP_PUSH);
  assign w_sp_dec = (r_state == S_ISSUE) && (r_op == OP_POP);

  dm_sp_reg #(
    .DATA_W      (DATA_W),
    .MEM_DEPTH   (MEM_DEPTH),
    .STACK_BASE  (STACK_BASE),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_sp (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_inc    (w_sp_inc),
    .i_dec    (w_sp_dec),
    .o_sp     (w_sp),
    .o_sp_dec (w_sp_dec_val),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // Request rejection: address range for LOAD/STORE, stack flags for PUSH/POP.
  always_comb begin
    w_req_err = 1'b0;
    case (w_op)
      OP_LOAD, OP_STORE: w_req_err = w_addr_oob;
      OP_PUSH:           w_req_err = w_full;
      OP_POP:            w_req_err = w_empty;
      default:           w_req_err = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next state: rejected requests skip straight to RESP, reads detour via CAPT.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_req_err ? S_RESP : S_ISSUE;
      S_ISSUE: w_next = op_reads(r_op) ? S_CAPT : S_RESP;
      S_CAPT:  w_next = S_RESP;
      S_RESP:  if (i_rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes, DM operands and response registers. Strobes are set on accept so
  // they are high for exactly the ISSUE cycle; pop pre-decrements the address
  // because DM reads mem[sp] while our sp points at the next free slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op        <= OP_LOAD;
      r_dm_load   <= 1'b0;
      r_dm_store  <= 1'b0;
      r_dm_push   <= 1'b0;
      r_dm_pop    <= 1'b0;
      r_dm_val    <= '0;
      r_dm_rez    <= '0;
      r_dm_sp     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_dm_load  <= 1'b0;
      r_dm_store <= 1'b0;
      r_dm_push  <= 1'b0;
      r_dm_pop   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op <= w_op;
            if (w_req_err) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_data  <= '0;
            end else begin
              r_dm_load  <= (w_op == OP_LOAD);
              r_dm_store <= (w_op == OP_STORE);
              r_dm_push  <= (w_op == OP_PUSH);
              r_dm_pop   <= (w_op == OP_POP);
              if (op_addressed(w_op))
                r_dm_val <= i_req_addr;
              if ((w_op == OP_STORE) || (w_op == OP_PUSH))
                r_dm_rez <= i_req_data;
              if (w_op == OP_PUSH)
                r_dm_sp <= w_sp;
              else if (w_op == OP_POP)
                r_dm_sp <= w_sp_dec_val;
            end
          end
        end
        S_ISSUE: begin
          if (!op_reads(r_op)) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
          end
        end
        S_CAPT: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_data  <= i_dm_out;
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_req_ready = (r_state == S_IDLE);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;
  assign o_dm_load   = r_dm_load;
  assign o_dm_store  = r_dm_store;
  assign o_dm_push   = r_dm_push;
  assign o_dm_pop    = r_dm_pop;
  assign o_dm_val    = r_dm_val;
  assign o_dm_rez    = r_dm_rez;
  assign o_dm_sp     = r_dm_sp;
  assign o_sp        = w_sp;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: a behavioural DM sits on the strobe side, and a
// transaction-level model (stack pointer as an integer, memory as an array)
// predicts every response, strobe, latency and sp value.
module tb_dm_access_ctrl;

`ifdef DM_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_addr, req_data;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_data;
  logic        dm_load, dm_store, dm_push, dm_pop;
  logic [15:0] dm_val, dm_rez, dm_sp, sp;
  logic [15:0] dm_out = 16'h0;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int msp;
  int ref_mem [256];

  always #5 clk = ~clk;

  dm_access_ctrl dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_op(req_op), .i_req_addr(req_addr), .i_req_data(req_data),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
    .o_dm_load(dm_load), .o_dm_store(dm_store),
    .o_dm_push(dm_push), .o_dm_pop(dm_pop),
    .o_dm_val(dm_val), .o_dm_rez(dm_rez), .o_dm_sp(dm_sp),
    .i_dm_out(dm_out), .o_sp(sp)
  );

  // Behavioural data memory: registered read, push writes mem[sp], pop reads mem[sp].
  logic [15:0] dm_mem [0:255] = '{default: 16'h0};
  always @(posedge clk) begin
    if (dm_store) dm_mem[dm_val[7:0]] <= dm_rez;
    if (dm_push)  dm_mem[dm_sp[7:0]]  <= dm_rez;
    if (dm_load)  dm_out <= dm_mem[dm_val[7:0]];
    if (dm_pop)   dm_out <= dm_mem[dm_sp[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = $urandom_range(0, 1);
    req_op = 2'($urandom); req_addr = 16'($urandom); req_data = 16'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", {dm_pop, dm_push, dm_store, dm_load}, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_sp", sp, 16'h00C0);
    chk("rst_req_ready", req_ready, 1);
    rst = 1'b0;
    req_valid = 1'b0;
    msp = 'hC0;
  endtask

  // One full transaction, entered and left at a negedge with the DUT idle.
  task automatic do_req(input int op, input int addr, input int data, input int hold);
    int err, lat, dmsp, rdata;
    logic [3:0] exp_stb;
    err = 0; dmsp = 0; rdata = 0;
    case (op)
      0, 1: err = (addr >= 256) ? 1 : 0;
      2:    err = (GUARD && msp == 'h100) ? 1 : 0;
      default: err = (GUARD && msp == 'hC0) ? 1 : 0;
    endcase
    if (err == 0) begin
      case (op)
        0: rdata = ref_mem[addr];
        1: ref_mem[addr] = data;
        2: begin
          dmsp = msp;
          ref_mem[msp % 256] = data;
          msp = GUARD ? msp + 1 : (msp + 1) % 256;
        end
        default: begin
          msp = GUARD ? msp - 1 : (msp + 255) % 256;
          dmsp = msp;
          rdata = ref_mem[msp % 256];
        end
      endcase
    end
    lat = (err != 0) ? 1 : ((op == 0 || op == 3) ? 3 : 2);
    exp_stb = (err != 0) ? 4'b0 : 4'(1 << op);

    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_op = 2'(op); req_addr = 16'(addr); req_data = 16'(data);
    @(posedge clk);
    #1;
    req_valid = $urandom_range(0, 1);
    req_op = 2'($urandom); req_addr = 16'($urandom); req_data = 16'($urandom);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("strobes", {dm_pop, dm_push, dm_store, dm_load}, (k == 1) ? exp_stb : 4'b0);
      if (k == 1 && err == 0) begin
        if (op <= 1) chk("dm_val", dm_val, addr);
        if (op == 1 || op == 2) chk("dm_rez", dm_rez, data);
        if (op >= 2) chk("dm_sp", dm_sp, dmsp);
      end
      chk("rsp_valid_lat", rsp_valid, (k == lat) ? 1 : 0);
      chk("req_ready_busy", req_ready, 0);
      if (k == lat) begin
        chk("rsp_data", rsp_data, rdata);
        chk("rsp_err", rsp_err, err);
      end
      rsp_ready = (k < lat) ? 1'($urandom_range(0, 1)) : (hold == 0);
    end
    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, rdata);
      chk("hold_err", rsp_err, err);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_strobes", {dm_pop, dm_push, dm_store, dm_load}, 0);
      if (h == hold) rsp_ready = 1'b1;
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("req_ready_back", req_ready, 1);
    chk("sp", sp, 16'(msp));
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = 16'h0;
    req_data = 16'h0; rsp_ready = 1'b0; msp = 'hC0;

    do_reset();

    // store then load back
    do_req(1, 'h0010, 'hBEEF, 0);
    do_req(0, 'h0010, 0, 0);
    chk("load_beef", rsp_data, 0);  // cleared once consumed
    // stack round trip
    do_req(2, 0, 'h1111, 0);
    do_req(2, 0, 'h2222, 0);
    do_req(3, 0, 0, 1);
    do_req(3, 0, 0, 0);
    chk("sp_back_base", sp, 16'h00C0);
    // out-of-range load and a load held for 5 cycles
    do_req(0, 'h0100, 0, 0);
    do_req(0, 'hFFFF, 0, 2);
    do_req(0, 'h0010, 0, 5);

    // pop on an empty stack
    do_reset();
    do_req(3, 0, 0, 0);

    // fill the stack, overflow by one, then pop across the low edge
    do_reset();
    for (int i = 0; i < 65; i++) do_req(2, 0, 'hA000 + i, 0);
    if (GUARD) chk("sp_full", sp, 16'h0100);
    for (int i = 0; i < 3; i++) do_req(3, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 80; i++) begin
      int op, addr;
      op = $urandom_range(0, 3);
      addr = ($urandom_range(0, 7) == 0) ? $urandom_range(256, 65535) : $urandom_range(0, 255);
      do_req(op, addr, $urandom_range(0, 65535), $urandom_range(0, 3));
    end

    // reset in the ISSUE cycle of a push
    do_reset();
    req_valid = 1'b1; req_op = 2'd2; req_data = 16'h5A5A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid_push_strobe", dm_push, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_strobes", {dm_pop, dm_push, dm_store, dm_load}, 0);
    chk("mid_rst_sp", sp, 16'h00C0);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    ref_mem[msp % 256] = 'h5A5A;  // the strobe reached DM before reset
    msp = 'hC0;
    do_req(3, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
